// File: rtl/pipeline_control.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_control
// Brief    : Stall/flush sequencer for the six-stage pipeline
//            (pc, if, id, ex, mem, wb). Merges load-use interlocks,
//            multicycle EX occupancy and flush/redirect requests.
// Options  : PIPELINE_CONTROL_STATISTICS_EN adds stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_control #(
    parameter int MULDIV_CYCLES = 32,
    parameter int COUNTER_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_request_id,
    input  logic        operation_start,
    input  logic        flush_request,
    input  logic [31:0] flush_target,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_program_counter,
    output logic        operation_busy,
    output logic        operation_done
`ifdef PIPELINE_CONTROL_STATISTICS_EN
    ,
    output logic [31:0] stall_cycle_count,
    output logic [15:0] flush_count
`endif
);

    // The start cycle itself counts as one busy cycle, so BUSY holds for
    // MULDIV_CYCLES-1 cycles: countdown runs from MULDIV_CYCLES-2 to 0.
    localparam logic [COUNTER_WIDTH-1:0] c_count_load = COUNTER_WIDTH'(MULDIV_CYCLES - 2);
    localparam logic [COUNTER_WIDTH-1:0] c_count_one  = COUNTER_WIDTH'(1);
    localparam logic [5:0]               c_stall_none = 6'b000000;
    localparam logic [5:0]               c_stall_ex   = 6'b001111;
    localparam logic [5:0]               c_stall_id   = 6'b000111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] w_count_next;
    logic                     r_flush;
    logic [31:0]              r_new_pc;
    logic [5:0]               w_stall;
    logic                     w_start;

    // A start is only accepted from IDLE, and a simultaneous flush drops it.
    assign w_start = (r_state == ST_IDLE) && operation_start && !flush_request;

    // State, countdown and registered flush/redirect outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_flush  <= 1'b0;
            r_new_pc <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_flush <= flush_request;
            if (flush_request) begin
                r_new_pc <= flush_target;
            end
        end
    end

    // Next-state and countdown; a flush request overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        if (flush_request) begin
            w_state_next = ST_FLUSH;
            w_count_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (operation_start) begin
                        w_state_next = ST_BUSY;
                        w_count_next = c_count_load;
                    end
                end
                ST_BUSY: begin
                    if (r_count == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_count_next = r_count - c_count_one;
                    end
                end
                ST_DONE:  w_state_next = ST_IDLE;
                ST_FLUSH: w_state_next = ST_IDLE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // Stall vector by priority: flush cycle, multicycle EX, load-use, none.
    always_comb begin
        w_stall = c_stall_none;
        if (r_state == ST_FLUSH) begin
            w_stall = c_stall_none;
        end else if (w_start || (r_state == ST_BUSY)) begin
            w_stall = c_stall_ex;
        end else if (stall_request_id) begin
            w_stall = c_stall_id;
        end
    end

    // Combinational outputs are forced quiet while reset is asserted.
    assign stall               = reset ? w_stall : c_stall_none;
    assign operation_busy      = reset && (w_start || (r_state == ST_BUSY));
    assign operation_done      = (r_state == ST_DONE);
    assign flush               = r_flush;
    assign new_program_counter = r_new_pc;

`ifdef PIPELINE_CONTROL_STATISTICS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_events;

    // Saturating counters of stalled cycles and FLUSH entries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if ((w_stall != c_stall_none) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (flush_request && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + 16'd1;
            end
        end
    end

    assign stall_cycle_count = r_stall_cycles;
    assign flush_count       = r_flush_events;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_control
// Brief    : Self-checking bench for pipeline_control: vector table,
//            directed multicycle/flush/reset sequences, randomized run
//            against a cycle-age reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_control;

    localparam int M = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sri   = 1'b0;
    logic        start = 1'b0;
    logic        freq  = 1'b0;
    logic [31:0] ftgt  = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] npc;
    logic        busy;
    logic        done;
`ifdef PIPELINE_CONTROL_STATISTICS_EN
    logic [31:0] scc;
    logic [15:0] fcnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    pipeline_control #(
        .MULDIV_CYCLES(M),
        .COUNTER_WIDTH(8)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .stall_request_id   (sri),
        .operation_start    (start),
        .flush_request      (freq),
        .flush_target       (ftgt),
        .stall              (stall),
        .flush              (flush),
        .new_program_counter(npc),
        .operation_busy     (busy),
        .operation_done     (done)
`ifdef PIPELINE_CONTROL_STATISTICS_EN
        ,
        .stall_cycle_count  (scc),
        .flush_count        (fcnt)
`endif
    );

    typedef struct {
        logic        sri;
        logic        start;
        logic        freq;
        logic [31:0] tgt;
        logic [5:0]  es;
        logic        eb;
        logic        ed;
        logic        ef;
        logic [31:0] ep;
    } vec_t;

    task automatic chk(input string name, input logic [5:0] es, input logic eb,
                       input logic ed, input logic ef, input logic [31:0] ep);
        n_checks++;
        if (stall === es && busy === eb && done === ed && flush === ef && npc === ep)
            n_pass++;
        else
            $display("FAIL %s @%0t: got stall=%b busy=%b done=%b flush=%b npc=%h, want stall=%b busy=%b done=%b flush=%b npc=%h",
                     name, $time, stall, busy, done, flush, npc, es, eb, ed, ef, ep);
    endtask

    task automatic set_in(input logic s, input logic st, input logic f, input logic [31:0] t);
        sri   = s;
        start = st;
        freq  = f;
        ftgt  = t;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: age of the running op in cycles since its start.
    int          m_age = -1;
    bit          m_fl  = 1'b0;
    logic [31:0] m_npc = 32'h0;

    task automatic model_check(input string name);
        logic [5:0] es;
        logic       eb;
        logic       ed;
        es = 6'b0; eb = 1'b0; ed = 1'b0;
        if (m_fl) begin
            es = 6'b0;
        end else if (m_age >= 1 && m_age < M) begin
            es = 6'b001111; eb = 1'b1;
        end else if (m_age == M) begin
            ed = 1'b1; es = sri ? 6'b000111 : 6'b0;
        end else if (start && !freq) begin
            es = 6'b001111; eb = 1'b1;
        end else begin
            es = sri ? 6'b000111 : 6'b0;
        end
        chk(name, es, eb, ed, m_fl, m_npc);
    endtask

    task automatic model_step();
        bit idle;
        idle = !m_fl && (m_age < 0);
        if (freq) begin
            m_fl  = 1'b1;
            m_age = -1;
            m_npc = ftgt;
        end else begin
            m_fl = 1'b0;
            if (m_age >= 1 && m_age < M)  m_age = m_age + 1;
            else if (m_age == M)          m_age = -1;
            else if (idle && start)       m_age = 1;
        end
    endtask

    vec_t        tbl [11];
    logic [31:0] cur_npc;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         6'b000111, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         6'b000111, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h1234_5678, 6'b000111, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b1, 32'h1234_5678};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'hA5A5_0000, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h1234_5678};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h8000_0180, 6'b000000, 1'b0, 1'b0, 1'b1, 32'hA5A5_0000};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b1, 32'h8000_0180};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 1'b0, 1'b0, 32'h8000_0180};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         6'b000111, 1'b0, 1'b0, 1'b0, 32'h8000_0180};

        // Reset state
        set_in(0, 0, 0, 32'h0);
        @(negedge clock);
        chk("reset_state", 6'b0, 0, 0, 0, 32'h0);
        #2 reset = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_after_reset", 6'b0, 0, 0, 0, 32'h0);
            tick();
        end

        // Vector table: load-use, flush, back-to-back flush, start in FLUSH
        foreach (tbl[i]) begin
            set_in(tbl[i].sri, tbl[i].start, tbl[i].freq, tbl[i].tgt);
            @(negedge clock);
            chk($sformatf("table_%0d", i), tbl[i].es, tbl[i].eb, tbl[i].ed, tbl[i].ef, tbl[i].ep);
            tick();
        end
        cur_npc = 32'h8000_0180;
        set_in(0, 0, 0, 32'h0);
        tick();

        // Full multicycle op; sri and stray starts during BUSY are absorbed
        set_in(0, 1, 0, 32'h0);
        @(negedge clock);
        chk("op_start", 6'b001111, 1, 0, 0, cur_npc);
        tick();
        for (int k = 1; k < M; k++) begin
            set_in(k == 3, k == 10, 0, 32'h0);
            @(negedge clock);
            chk($sformatf("op_busy_%0d", k), 6'b001111, 1, 0, 0, cur_npc);
            tick();
        end
        set_in(1, 1, 0, 32'h0);
        @(negedge clock);
        chk("op_done_sri", 6'b000111, 0, 1, 0, cur_npc);
        tick();
        set_in(0, 0, 0, 32'h0);
        @(negedge clock);
        chk("after_done_idle", 6'b0, 0, 0, 0, cur_npc);
        tick();

        // Flush aborts a running op; no done pulse afterwards
        set_in(0, 1, 0, 32'h0);
        @(negedge clock);
        chk("abort_start", 6'b001111, 1, 0, 0, cur_npc);
        tick();
        for (int k = 1; k <= 7; k++) begin
            set_in(0, 0, k == 7, (k == 7) ? 32'h0000_0180 : 32'h0);
            @(negedge clock);
            chk("abort_busy", 6'b001111, 1, 0, 0, cur_npc);
            tick();
        end
        set_in(0, 0, 0, 32'h0);
        @(negedge clock);
        chk("abort_flush", 6'b0, 0, 0, 1, 32'h0000_0180);
        tick();
        cur_npc = 32'h0000_0180;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            chk("abort_no_done", 6'b0, 0, 0, 0, cur_npc);
            tick();
        end

        // Simultaneous start and flush: flush wins, no BUSY entry
        set_in(0, 1, 1, 32'hBFC0_0000);
        tick();
        set_in(0, 0, 0, 32'h0);
        @(negedge clock);
        chk("simul_flush", 6'b0, 0, 0, 1, 32'hBFC0_0000);
        tick();
        cur_npc = 32'hBFC0_0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("simul_no_busy", 6'b0, 0, 0, 0, cur_npc);
            tick();
        end

        // Asynchronous reset mid-BUSY, then a fresh full-latency op
        set_in(0, 1, 0, 32'h0);
        tick();
        set_in(0, 0, 0, 32'h0);
        for (int k = 0; k < 5; k++) tick();
        #2 reset = 1'b0;
        #1;
        chk("async_reset_now", 6'b0, 0, 0, 0, 32'h0);
        @(negedge clock);
        chk("async_reset_hold", 6'b0, 0, 0, 0, 32'h0);
        @(posedge clock);
        #3 reset = 1'b1;
        tick();
        set_in(0, 1, 0, 32'h0);
        @(negedge clock);
        chk("post_reset_start", 6'b001111, 1, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 0, 32'h0);
        for (int k = 1; k < M; k++) begin
            @(negedge clock);
            chk("post_reset_busy", 6'b001111, 1, 0, 0, 32'h0);
            tick();
        end
        @(negedge clock);
        chk("post_reset_done", 6'b0, 0, 1, 0, 32'h0);
        tick();
        set_in(1, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) tick();
        set_in(0, 0, 1, 32'h0000_4000);
        tick();
        set_in(0, 0, 0, 32'h0);
        tick();
        tick();
`ifdef PIPELINE_CONTROL_STATISTICS_EN
        n_checks++;
        if (scc === 32'd35 && fcnt === 16'd1) n_pass++;
        else $display("FAIL stats: got stall_cycles=%0d flush_count=%0d, want 35 and 1", scc, fcnt);
`endif

        // Randomized run against the reference model
        m_age = -1;
        m_fl  = 1'b0;
        m_npc = 32'h0000_4000;
        for (int c = 0; c < 3000; c++) begin
            set_in(($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 40) == 0, $urandom);
            @(negedge clock);
            model_check("random");
            model_step();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
